mult_reservation_station: RTL and testbench
===========================================

MULT_RESERVATION_STATION -- requirements
Module: mult_reservation_station

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, meaning the number of station slots (power of two, at least 2).
REQ-002 SHALL have parameter PREG_BITS, default 6, meaning the physical-register index width.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-004 SHALL have port rst, input, 1 bit, meaning reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port dispatch_valid, input, 1 bit, meaning a dispatch request this cycle.
REQ-006 SHALL have port dispatch_entry, input, mult_rs_entry_t, meaning the dispatched instruction: pd, rd, ps1, ps2, ps1_ready, ps2_ready, funct3, opcode, rob_entry_idx, pc.
REQ-007 SHALL have port rs_full, output, 1 bit, meaning no free slot; dispatch must be held off.
REQ-008 SHALL have port cdb_valid, input, 1 bit, meaning the CDB broadcast is valid.
REQ-009 SHALL have port cdb_pd, input, PREG_BITS, meaning the physical register being broadcast.
REQ-010 SHALL have port flush, input, 1 bit, meaning a synchronous squash of all held state.
REQ-011 SHALL have port mult_is_ready_to_RS, input, 1 bit, meaning the multiplier accepts the current issue this cycle.
REQ-012 SHALL have port rs_to_mult, output, rs_to_mult_t, meaning the issued instruction with its valid bit.
REQ-013 SHALL have ports ps1_idx and ps2_idx, output, PREG_BITS each, meaning the register-file read addresses for rs_to_mult.

Function
REQ-014 SHALL organise slots as a compacting age-ordered queue: slot 0 oldest; the count ranges 0..NUM_ENTRIES.
REQ-015 SHALL assert rs_full exactly when the count equals NUM_ENTRIES; no credit is given for a same-cycle issue.
REQ-016 SHALL write a dispatch when dispatch_valid and !rs_full, into slot count (after compaction), and SHALL ignore dispatch while full.
REQ-017 SHALL set a slot's psN_ready when cdb_valid and cdb_pd equals psN; this applies to held slots and, bypassed, to the same-cycle dispatch.
REQ-018 SHALL treat a physical index of 0 as always ready.
REQ-019 SHALL, when the issue register is empty or mult_is_ready_to_RS=1, select the lowest-index slot with both operands ready (state as of the start of the cycle), load it into the issue register, and remove it with the younger slots shifting down one.
REQ-020 SHALL otherwise hold the issue register unchanged, and SHALL clear its valid when it is consumed and no ready slot exists.
REQ-021 SHALL drive rs_to_mult and ps1_idx/ps2_idx from the issue register, giving 1-cycle dispatch-to-issue latency minimum; a CDB-woken slot issues the cycle after wakeup at earliest.
REQ-022 SHALL handle dispatch, wakeup and issue in the same cycle without loss or duplication; the count changes by +1, 0 or -1.
REQ-023 SHALL, on flush, clear all slot valids, the count and the issue register at the next edge; flush takes precedence over dispatch and issue.
REQ-024 SHALL never issue a slot whose ready bits are not both set, and SHALL issue each slot exactly once.

Reset
REQ-025 SHALL, while rst is high (asynchronously), clear all slot valids, ready bits, the count and the issue register.
REQ-026 SHALL output rs_full=0, rs_to_mult='0 (valid=0) and ps1_idx=ps2_idx=0 during reset.
REQ-027 SHALL discard any in-flight dispatch when rst asserts mid-operation.

Structure
REQ-028 SHALL place mult_rs_entry_t and rs_to_mult_t in rv32i_types.
REQ-029 SHALL implement selection in one sub-module, rs_oldest_ready_select: a priority encoder producing the index and a found flag.

Verification
REQ-030 Empty station, dispatch pd=5 with ps1=3 and ps2=4 both ready, mult ready -> rs_to_mult.valid=1, pd=5 next cycle; ps1_idx=3.
REQ-031 Dispatch 4 not-ready entries -> rs_full=1; a 5th dispatch is ignored; CDB pd matching slot 2's operands -> only slot 2 issues, and rs_full drops.
REQ-032 Two ready entries A (older), B; mult_is_ready_to_RS=0 for 3 cycles -> A held stable; on release A issues, then B the next cycle.
REQ-033 Dispatch with ps2=7 not ready while cdb_pd=7 is valid in the same cycle -> the entry issues the next cycle.
REQ-034 Full station plus a valid issue, then flush -> next cycle count=0, rs_to_mult.valid=0, rs_full=0; a same-cycle dispatch is dropped.
REQ-035 rst asserted asynchronously mid-cycle with 3 entries held -> outputs clear immediately; no issue after release until a new dispatch.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I backend types: multiplier reservation-station entries and the
// issue bundle handed to the multiplier.
package rv32i_types;

  localparam int unsigned PREG_W    = 6;
  localparam int unsigned ROB_IDX_W = 4;

  typedef struct packed {
    logic [PREG_W-1:0]    pd;
    logic [4:0]           rd;
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic                 ps1_ready;
    logic                 ps2_ready;
    logic [2:0]           funct3;
    logic [6:0]           opcode;
    logic [ROB_IDX_W-1:0] rob_entry_idx;
    logic [31:0]          pc;
  } mult_rs_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    pd;
    logic [4:0]           rd;
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [2:0]           funct3;
    logic [6:0]           opcode;
    logic [ROB_IDX_W-1:0] rob_entry_idx;
    logic [31:0]          pc;
  } rs_to_mult_t;

  function automatic rs_to_mult_t to_issue(input mult_rs_entry_t e);
    rs_to_mult_t r;
    r.valid         = 1'b1;
    r.pd            = e.pd;
    r.rd            = e.rd;
    r.ps1           = e.ps1;
    r.ps2           = e.ps2;
    r.funct3        = e.funct3;
    r.opcode        = e.opcode;
    r.rob_entry_idx = e.rob_entry_idx;
    r.pc            = e.pc;
    return r;
  endfunction

endpackage

// File: rtl/rs_oldest_ready_select.sv
// Priority encoder: index of the lowest-numbered (oldest) ready slot.
module rs_oldest_ready_select #(
  parameter int unsigned NUM_ENTRIES = 4
) (
  input  logic [NUM_ENTRIES-1:0]         ready_i,
  output logic [$clog2(NUM_ENTRIES)-1:0] idx_o,
  output logic                           found_o
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (ready_i[i] && !found_o) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mult_reservation_station.sv
// Multiplier reservation station: compacting age-ordered queue with CDB wakeup
// and a single registered issue slot toward the multiplier.
module mult_reservation_station
  import rv32i_types::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned PREG_BITS   = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dispatch_valid,
  input  mult_rs_entry_t       dispatch_entry,
  output logic                 rs_full,
  input  logic                 cdb_valid,
  input  logic [PREG_BITS-1:0] cdb_pd,
  input  logic                 flush,
  input  logic                 mult_is_ready_to_RS,
  output rs_to_mult_t          rs_to_mult,
  output logic [PREG_BITS-1:0] ps1_idx,
  output logic [PREG_BITS-1:0] ps2_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
  localparam int unsigned CNT_W = $clog2(NUM_ENTRIES + 1);

  mult_rs_entry_t         slots_q [NUM_ENTRIES];
  mult_rs_entry_t         slots_d [NUM_ENTRIES];
  logic [CNT_W-1:0]       count_q, count_d;
  rs_to_mult_t            issue_q, issue_d;

  logic [NUM_ENTRIES-1:0] ready_vec;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_found;
  logic                   can_issue;
  logic                   do_remove;
  logic                   accept;
  logic [CNT_W-1:0]       count_rem;
  mult_rs_entry_t         new_entry;

  function automatic mult_rs_entry_t wake(input mult_rs_entry_t e,
                                          input logic cv,
                                          input logic [PREG_BITS-1:0] cpd);
    mult_rs_entry_t w;
    w = e;
    if (cv && (PREG_BITS'(e.ps1) == cpd)) w.ps1_ready = 1'b1;
    if (cv && (PREG_BITS'(e.ps2) == cpd)) w.ps2_ready = 1'b1;
    return w;
  endfunction

  assign rs_full    = (count_q == CNT_W'(NUM_ENTRIES));
  assign rs_to_mult = issue_q;
  assign ps1_idx    = PREG_BITS'(issue_q.ps1);
  assign ps2_idx    = PREG_BITS'(issue_q.ps2);

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      ready_vec[i] = (CNT_W'(i) < count_q) && slots_q[i].ps1_ready && slots_q[i].ps2_ready;
    end
  end

  rs_oldest_ready_select #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_select (
    .ready_i (ready_vec),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  always_comb begin
    can_issue = !issue_q.valid || mult_is_ready_to_RS;
    do_remove = can_issue && sel_found;

    issue_d = issue_q;
    if (can_issue) begin
      if (sel_found) issue_d = to_issue(slots_q[sel_idx]);
      else           issue_d.valid = 1'b0;
    end

    // Compact first (slots at/above the issued one shift down), then wake the result.
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      slots_d[i] = slots_q[i];
      if (do_remove && (IDX_W'(i) >= sel_idx)) begin
        slots_d[i] = (i == NUM_ENTRIES - 1) ? '0 : slots_q[(i + 1) % NUM_ENTRIES];
      end
      slots_d[i] = wake(slots_d[i], cdb_valid, cdb_pd);
    end

    count_rem = count_q - CNT_W'(do_remove);
    accept    = dispatch_valid && !rs_full;

    new_entry = dispatch_entry;
    if (dispatch_entry.ps1 == '0) new_entry.ps1_ready = 1'b1;
    if (dispatch_entry.ps2 == '0) new_entry.ps2_ready = 1'b1;
    new_entry = wake(new_entry, cdb_valid, cdb_pd);

    if (accept) slots_d[count_rem[IDX_W-1:0]] = new_entry;
    count_d = count_rem + CNT_W'(accept);

    if (flush) begin
      count_d = '0;
      issue_d = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) slots_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      issue_q <= '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) slots_q[i] <= '0;
    end else begin
      count_q <= count_d;
      issue_q <= issue_d;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) slots_q[i] <= slots_d[i];
    end
  end

endmodule

// File: tb/tb_mult_reservation_station.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the station.
module tb_mult_reservation_station;
  import rv32i_types::*;

  localparam int unsigned NE = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           dispatch_valid = 1'b0;
  mult_rs_entry_t dispatch_entry = '0;
  logic           rs_full;
  logic           cdb_valid = 1'b0;
  logic [5:0]     cdb_pd = '0;
  logic           flush = 1'b0;
  logic           mult_is_ready_to_RS = 1'b1;
  rs_to_mult_t    rs_to_mult;
  logic [5:0]     ps1_idx, ps2_idx;

  int checks = 0;
  int errors = 0;

  mult_rs_entry_t mq[$];
  rs_to_mult_t    m_issue = '0;

  mult_reservation_station #(.NUM_ENTRIES(NE), .PREG_BITS(6)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .dispatch_valid      (dispatch_valid),
    .dispatch_entry      (dispatch_entry),
    .rs_full             (rs_full),
    .cdb_valid           (cdb_valid),
    .cdb_pd              (cdb_pd),
    .flush               (flush),
    .mult_is_ready_to_RS (mult_is_ready_to_RS),
    .rs_to_mult          (rs_to_mult),
    .ps1_idx             (ps1_idx),
    .ps2_idx             (ps2_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic op_rdy(input logic [5:0] ps, input logic r);
    return r || (ps == 6'd0);
  endfunction

  function automatic rs_to_mult_t model_issue(input mult_rs_entry_t e);
    rs_to_mult_t r;
    r = '{valid: 1'b1, pd: e.pd, rd: e.rd, ps1: e.ps1, ps2: e.ps2, funct3: e.funct3,
          opcode: e.opcode, rob_entry_idx: e.rob_entry_idx, pc: e.pc};
    return r;
  endfunction

  // One clock of the station's rules, applied to the current inputs.
  task automatic model_step();
    bit             full;
    int             k;
    mult_rs_entry_t e;
    if (flush) begin
      mq.delete();
      m_issue = '0;
      return;
    end
    full = (mq.size() == NE);
    if (!m_issue.valid || mult_is_ready_to_RS) begin
      k = -1;
      foreach (mq[j]) if (k < 0 && op_rdy(mq[j].ps1, mq[j].ps1_ready) && op_rdy(mq[j].ps2, mq[j].ps2_ready)) k = j;
      if (k >= 0) begin
        m_issue = model_issue(mq[k]);
        mq.delete(k);
      end else begin
        m_issue.valid = 1'b0;
      end
    end
    foreach (mq[j]) begin
      if (cdb_valid && cdb_pd == mq[j].ps1) mq[j].ps1_ready = 1'b1;
      if (cdb_valid && cdb_pd == mq[j].ps2) mq[j].ps2_ready = 1'b1;
    end
    if (dispatch_valid && !full) begin
      e = dispatch_entry;
      if (cdb_valid && cdb_pd == e.ps1) e.ps1_ready = 1'b1;
      if (cdb_valid && cdb_pd == e.ps2) e.ps2_ready = 1'b1;
      mq.push_back(e);
    end
  endtask

  task automatic compare_all();
    chk("rs_full", 128'(rs_full), 128'(mq.size() == NE));
    chk("rs_to_mult", 128'(rs_to_mult), 128'(m_issue));
    chk("ps1_idx", 128'(ps1_idx), 128'(m_issue.ps1));
    chk("ps2_idx", 128'(ps2_idx), 128'(m_issue.ps2));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle();
    dispatch_valid      = 1'b0;
    cdb_valid           = 1'b0;
    flush               = 1'b0;
    mult_is_ready_to_RS = 1'b1;
  endtask

  function automatic mult_rs_entry_t mk(input logic [5:0] pd, input logic [5:0] ps1,
                                        input logic [5:0] ps2, input logic r1, input logic r2);
    mult_rs_entry_t e;
    e = '{pd: pd, rd: pd[4:0], ps1: ps1, ps2: ps2, ps1_ready: r1, ps2_ready: r2,
          funct3: 3'(pd), opcode: 7'h33, rob_entry_idx: pd[3:0], pc: $urandom};
    return e;
  endfunction

  initial begin
    // Reset state
    #1;
    chk("reset_rs_full", 128'(rs_full), 128'(0));
    chk("reset_issue", 128'(rs_to_mult), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Ready dispatch issues on the cycle after it lands
    dispatch_valid = 1'b1; dispatch_entry = mk(6'd5, 6'd3, 6'd4, 1'b1, 1'b1);
    step();
    idle();
    step();
    chk("basic_valid", 128'(rs_to_mult.valid), 128'(1));
    chk("basic_pd", 128'(rs_to_mult.pd), 128'(5));
    chk("basic_ps1_idx", 128'(ps1_idx), 128'(3));
    step();

    // Fill with not-ready entries, overflow dispatch, wake slot 2 only
    for (int k = 0; k < 5; k++) begin
      dispatch_valid = 1'b1;
      dispatch_entry = mk(6'(30 + k), 6'(10 + k), 6'(20 + k), 1'b0, 1'b0);
      step();
    end
    idle();
    chk("full_after_fill", 128'(rs_full), 128'(1));
    chk("fifth_ignored", 128'(mq.size()), 128'(4));
    cdb_valid = 1'b1; cdb_pd = 6'd12; step();
    cdb_pd = 6'd22; step();
    idle();
    step();
    chk("slot2_issue_pd", 128'(rs_to_mult.pd), 128'(32));
    chk("slot2_full_drops", 128'(rs_full), 128'(0));

    // Full station with held issue, then flush with a same-cycle dispatch
    mult_is_ready_to_RS = 1'b0;
    dispatch_valid = 1'b1; dispatch_entry = mk(6'd35, 6'd15, 6'd25, 1'b0, 1'b0);
    step();
    chk("full_before_flush", 128'(rs_full), 128'(1));
    chk("issue_before_flush", 128'(rs_to_mult.valid), 128'(1));
    flush = 1'b1; dispatch_entry = mk(6'd36, 6'd0, 6'd0, 1'b1, 1'b1);
    step();
    chk("flush_full", 128'(rs_full), 128'(0));
    chk("flush_issue", 128'(rs_to_mult.valid), 128'(0));
    idle();
    flush = 1'b1; dispatch_valid = 1'b1;
    step();
    idle();
    step();
    step();
    chk("flush_drops_dispatch", 128'(rs_to_mult.valid), 128'(0));

    // Back-pressure holds the older entry stable
    mult_is_ready_to_RS = 1'b0;
    dispatch_valid = 1'b1; dispatch_entry = mk(6'd40, 6'd1, 6'd2, 1'b1, 1'b1);
    step();
    dispatch_entry = mk(6'd41, 6'd3, 6'd0, 1'b1, 1'b0);
    step();
    dispatch_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("held_pd", 128'(rs_to_mult.pd), 128'(40));
    end
    mult_is_ready_to_RS = 1'b1;
    step();
    chk("release_b_pd", 128'(rs_to_mult.pd), 128'(41));
    step();
    chk("drained_valid", 128'(rs_to_mult.valid), 128'(0));

    // Same-cycle CDB bypass into the dispatched entry
    dispatch_valid = 1'b1; dispatch_entry = mk(6'd50, 6'd6, 6'd7, 1'b1, 1'b0);
    cdb_valid = 1'b1; cdb_pd = 6'd7;
    step();
    idle();
    step();
    chk("bypass_valid", 128'(rs_to_mult.valid), 128'(1));
    chk("bypass_pd", 128'(rs_to_mult.pd), 128'(50));
    step();

    // Asynchronous reset mid-cycle with three entries held
    for (int k = 0; k < 3; k++) begin
      dispatch_valid = 1'b1;
      dispatch_entry = mk(6'(1 + k), 6'(44 + k), 6'(47 + k), 1'b0, 1'b0);
      step();
    end
    dispatch_entry = mk(6'd9, 6'd0, 6'd0, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_issue", 128'(rs_to_mult), 128'(0));
    chk("async_rst_full", 128'(rs_full), 128'(0));
    chk("async_rst_ps1", 128'(ps1_idx), 128'(0));
    mq.delete();
    m_issue = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int k = 0; k < 6; k++) begin
      cdb_valid = 1'b1; cdb_pd = 6'(44 + k);
      step();
    end
    idle();
    step();
    chk("no_issue_after_rst", 128'(rs_to_mult.valid), 128'(0));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      dispatch_valid      = ($urandom_range(0, 9) < 6);
      dispatch_entry      = mk(6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
                               6'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                               ($urandom_range(0, 3) == 0));
      cdb_valid           = $urandom_range(0, 1);
      cdb_pd              = 6'($urandom_range(0, 7));
      mult_is_ready_to_RS = ($urandom_range(0, 9) < 7);
      flush               = ($urandom_range(0, 99) < 3);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
